mp_add_seq: RTL

Multi-precision add sequencer built around the team's 8-bit ripple carry adder. It accepts two NBYTES-byte operands and a carry-in over a valid/ready handshake. It feeds the adder one byte per step, least-significant byte first, and chains the carry through a register. The ripple path is treated as a multicycle path, so each byte is given SETTLE clock cycles to propagate before the sum is captured. The full result and carry-out are then presented on an output valid/ready handshake.

---
 rtl/mp_add_seq_pkg.sv | 27 ++
 rtl/mp_add_seq_if.sv | 40 ++++
 rtl/mp_add_seq_rca.sv | 29 ++
 rtl/mp_add_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/mp_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_pkg
//  Description : Shared constants, state encoding and a helper function for
//                the multi-precision add sequencer.
//                BYTE_W      - width of one adder slice
//                state_t     - sequencer state encoding
//                clog2_min1  - counter width that never collapses to zero
//  Revision    : 1.0  initial release
// ============================================================================
package mp_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-entry counter still needs a 1-bit register.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_seq_if
//  Description : Operand/result handshake bundle for mp_add_seq.
//                in_valid/in_ready + a_in, b_in, cin_in   : operand channel
//                out_valid/out_ready + sum_out, cout_out  : result channel
//                busy                                     : status
//                slave modport = sequencer, master modport = its user
//  Revision    : 1.0  initial release
// ============================================================================
interface mp_add_seq_if
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
);
    localparam int W = BYTE_W * NBYTES;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           cin_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sum_out;
    logic           cout_out;
    logic           busy;

    modport slave (
        input  in_valid, a_in, b_in, cin_in, out_ready,
        output in_ready, out_valid, sum_out, cout_out, busy
    );

    modport master (
        output in_valid, a_in, b_in, cin_in, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, busy
    );

endinterface
`default_nettype wire

// File: rtl/mp_add_seq_rca.sv
`default_nettype none
// ============================================================================
//  Module      : rca_8bits
//  Description : Purely combinational 8-bit ripple carry adder.
//                ain, bin : addends      cin  : carry in
//                sum      : ain+bin+cin  cout : carry out of bit 7
//  Revision    : 1.0  initial release
// ============================================================================
module rca_8bits (
    input  wire logic [7:0] ain,
    input  wire logic [7:0] bin,
    input  wire logic       cin,
    output logic      [7:0] sum,
    output logic            cout
);

    logic [8:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = ain[i] ^ bin[i] ^ w_c[i];
        assign w_c[i+1] = (ain[i] & bin[i]) | (w_c[i] & (ain[i] ^ bin[i]));
    end

    assign cout = w_c[8];

endmodule
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_seq
//  Description : Multi-precision add sequencer. Adds two NBYTES-byte operands
//                plus carry-in one byte per step, LSB first, through a single
//                rca_8bits. Each byte is held SETTLE cycles on the adder before
//                its sum is captured (ripple path is a multicycle path).
//                clk, reset : clock, synchronous active-high reset
//                bus        : operand/result handshake (mp_add_seq_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int SETTLE = 1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mp_add_seq_if.slave bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = clog2_min1(NBYTES);
    localparam int CNT_W = clog2_min1(SETTLE);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(SETTLE - 1);

    localparam logic [1:0] c_IDLE = IDLE;
    localparam logic [1:0] c_ADD  = ADD;
    localparam logic [1:0] c_DONE = DONE;

    logic [1:0]        r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;

    logic [7:0]        w_ain;
    logic [7:0]        w_bin;
    logic [7:0]        w_sum;
    logic              w_cout;
    logic              w_capture;

    // Adder inputs come only from registers, so they move only when r_idx or
    // r_carry change, i.e. at capture edges.
    assign w_ain = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_bin = r_b[r_idx*BYTE_W +: BYTE_W];

    rca_8bits u_rca (
        .ain  (w_ain),
        .bin  (w_bin),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_capture = (r_state == c_ADD) && (r_cnt == c_LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_carry <= bus.cin_in;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ADD;
                    end
                end
                c_ADD: begin
                    if (w_capture) begin
                        r_sum[r_idx*BYTE_W +: BYTE_W] <= w_sum;
                        r_carry <= w_cout;
                        r_cnt   <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // in_ready is held low while reset is asserted, then rises as soon as the
    // sequencer sits in IDLE with reset released.
    assign bus.in_ready  = (r_state == c_IDLE) && !reset;
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.sum_out   = r_sum;
    assign bus.cout_out  = (r_state == c_DONE) && r_carry;
    assign bus.busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire
